// File: rtl/txeipsum_pkg.sv
// Shared Ethernet/IPv4 constants and the ones-complement fold used by the TX
// checksum inserters.
package txeipsum_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          ETH_HDR_LEN    = 14;
  localparam int          IP_CSUM_OFF    = 24;
  localparam int          ETH_MIN_FRAME  = 60;

  // One result-FIFO entry: insert flag plus the final (inverted) checksum.
  typedef struct packed {
    logic        ins;
    logic [15:0] csum;
  } csum_ent_t;

  // Fold a 17-bit end-around-carry sum to 16 bits. The second add cannot carry:
  // if the first add carried, its low 16 bits are zero.
  function automatic logic [15:0] oc_fold(input logic [16:0] a);
    logic [16:0] t;
    t = {1'b0, a[15:0]} + {16'h0, a[16]};
    return t[15:0] + {15'h0, t[16]};
  endfunction

endpackage

// File: rtl/txeipsum_if.sv
// Byte-stream bus of the TX checksum inserter: frame bytes in, delayed and
// patched frame bytes out. master = upstream/bench, slave = the inserter.
interface txeipsum_if;
  logic       i_en;
  logic       i_v;
  logic [7:0] i_d;
  logic       o_v;
  logic [7:0] o_d;

  modport master (output i_en, i_v, i_d, input  o_v, o_d);
  modport slave  (input  i_en, i_v, i_d, output o_v, o_d);
endinterface

// File: rtl/txedelay.sv
// Circular-buffer delay line, 2^LGDELAY slots of W bits. One write and one
// read every cycle. The read slot is the one the writer reaches next, so the
// combinational output is 2^LGDELAY-1 cycles behind the input; the consumer's
// output register brings the total to exactly 2^LGDELAY.
module txedelay #(
  parameter int LGDELAY = 6,
  parameter int W       = 9
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);
  localparam int N = 1 << LGDELAY;

  logic [W-1:0]       r_mem [N];
  logic [LGDELAY-1:0] r_ptr;
  logic [LGDELAY-1:0] w_rd;

  assign w_rd = r_ptr + 1'b1;
  assign o_d  = r_mem[w_rd];

  // Write the incoming word and advance; reset clears every slot so no stale
  // valid bit survives a mid-frame reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= '0;
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else begin
      r_ptr        <= r_ptr + 1'b1;
      r_mem[r_ptr] <= i_d;
    end
  end

endmodule

// File: rtl/txeipsum.sv
// TX IPv4 header checksum inserter. Sums the IP header as bytes arrive,
// queues the result in a 2-entry FIFO, and patches frame bytes 24-25 as the
// frame leaves a 2^LGDELAY-byte delay line. LGDELAY must be >= 6 so the
// whole header (up to 60 bytes) is summed before byte 24 reaches the output.
// Optional: TXEIPSUM_PASSTHRU_EN keeps a nonzero software-supplied checksum.
module txeipsum
  import txeipsum_pkg::*;
#(
  parameter int LGDELAY = 6
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  txeipsum_if.slave bus
);

  logic       w_iv;
  logic [7:0] w_id;
  assign w_iv = bus.i_v;
  assign w_id = bus.i_d;

  // ---------------- input side: qualify and sum ----------------
  logic [6:0]  r_c, r_hend;
  logic        r_inv, r_qual, r_etok, r_ipok, r_pushed;
  logic [7:0]  r_hi;
  logic [16:0] r_acc;
  logic [15:0] w_word;
  logic [16:0] w_acc_nx;
  logic        w_hlast, w_abort, w_push, w_ins;
  csum_ent_t   w_ent;

  // The checksum field itself counts as zero.
  assign w_word   = (r_c == 7'(IP_CSUM_OFF + 1)) ? 16'h0 : {r_hi, w_id};
  assign w_acc_nx = {1'b0, r_acc[15:0]} + {16'h0, r_acc[16]} + {1'b0, w_word};
  assign w_hlast  = w_iv && r_ipok && !r_pushed && (r_c == r_hend);
  assign w_abort  = r_inv && !w_iv && !r_pushed;
  assign w_push   = w_hlast || w_abort;
  assign w_ent    = {w_ins, ~oc_fold(w_acc_nx)};

`ifdef TXEIPSUM_PASSTHRU_EN
  logic r_swcs;
  // Remember whether software already filled the checksum field.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                   r_swcs <= 1'b0;
    else if (!w_iv)                                   r_swcs <= 1'b0;
    else if ((r_c == 7'(IP_CSUM_OFF) || r_c == 7'(IP_CSUM_OFF + 1)) && w_id != 8'h0)
                                                      r_swcs <= 1'b1;
  end
  assign w_ins = w_hlast && r_qual && !r_swcs;
`else
  assign w_ins = w_hlast && r_qual;
`endif

  // Byte counter, frame qualification and header accumulation.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_c <= '0; r_hend <= '0; r_inv <= 1'b0; r_qual <= 1'b0; r_etok <= 1'b0;
      r_ipok <= 1'b0; r_pushed <= 1'b0; r_hi <= '0; r_acc <= '0;
    end else begin
      r_inv <= w_iv;
      if (!w_iv) begin
        r_c <= '0; r_etok <= 1'b0; r_ipok <= 1'b0; r_pushed <= 1'b0; r_acc <= '0;
      end else begin
        if (r_c != 7'd127) r_c <= r_c + 7'd1;
        if (r_c == 7'd0)   r_qual <= bus.i_en;
        if (r_c == 7'd12)  r_etok <= (w_id == ETHERTYPE_IPV4[15:8]);
        if (r_c == 7'd13)  r_etok <= r_etok && (w_id == ETHERTYPE_IPV4[7:0]);
        if (r_c == 7'(ETH_HDR_LEN)) begin
          r_ipok <= r_etok && (w_id[7:4] == 4'h4) && (w_id[3:0] >= 4'd5);
          r_hend <= 7'(ETH_HDR_LEN - 1) + {1'b0, w_id[3:0], 2'b00};
        end
        if (!r_c[0]) r_hi <= w_id;
        if (r_ipok && r_c[0] && r_c <= r_hend) r_acc <= w_acc_nx;
        if (w_hlast) r_pushed <= 1'b1;
      end
    end
  end

  // ---------------- result FIFO ----------------
  csum_ent_t [1:0] r_fifo;
  logic            r_wp, r_rp, r_ovf;
  logic [1:0]      r_cnt;
  logic            w_pop, w_push_ok;
  logic            r_ov;
  logic [7:0]      r_od;
  logic [8:0]      w_dl;
  logic            w_dv;
  logic [7:0]      w_dd;

  assign w_dv      = w_dl[8];
  assign w_dd      = w_dl[7:0];
  assign w_pop     = r_ov && !w_dv && (r_cnt != 2'd0);
  assign w_push_ok = w_push && ((r_cnt != 2'd2) || w_pop);

  // Push one entry per frame, pop at the last output byte; a push into a full
  // FIFO is dropped and latched in r_ovf.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fifo <= '0; r_wp <= 1'b0; r_rp <= 1'b0; r_cnt <= '0; r_ovf <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wp] <= w_ent;
        r_wp         <= ~r_wp;
      end
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push_ok} - {1'b0, w_pop};
    end
  end

  a_no_ovf: assert property (@(posedge i_clk) disable iff (!i_reset_n) !r_ovf);

  // ---------------- output side ----------------
  txedelay #(.LGDELAY(LGDELAY), .W(9)) u_dly (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       ({w_iv, w_id}),
    .o_d       (w_dl)
  );

  logic [6:0] r_k;
  logic       w_hins;
  csum_ent_t  w_head;

  assign w_head = r_fifo[r_rp];
  assign w_hins = (r_cnt != 2'd0) && w_head.ins;

  // Output byte counter and registered output with checksum substitution.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_k <= '0; r_ov <= 1'b0; r_od <= '0;
    end else begin
      r_ov <= w_dv;
      r_od <= w_dd;
      if (!w_dv)               r_k <= '0;
      else if (r_k != 7'd127)  r_k <= r_k + 7'd1;
      if (w_dv && w_hins && r_k == 7'(IP_CSUM_OFF))     r_od <= w_head.csum[15:8];
      if (w_dv && w_hins && r_k == 7'(IP_CSUM_OFF + 1)) r_od <= w_head.csum[7:0];
    end
  end

  assign bus.o_v = r_ov;
  assign bus.o_d = r_od;

endmodule
